// File: rtl/gfx_pkg.sv
// -----------------------------------------------------------------------------
// gfx_pkg
// Shared definitions for the graphics command scheduler:
//   - opcode constants accepted on cmd_op (LINE, RECT_FILL, RECT_MOVE)
//   - sched_state_t, the scheduler FSM state type
//   - is_known_op(), true for any opcode that maps to an engine
// -----------------------------------------------------------------------------
package gfx_pkg;

    localparam logic [31:0] LINE      = 32'd1;
    localparam logic [31:0] RECT_FILL = 32'd2;
    localparam logic [31:0] RECT_MOVE = 32'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

    function automatic logic is_known_op(input logic [31:0] op);
        return (op == LINE) || (op == RECT_FILL) || (op == RECT_MOVE);
    endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// -----------------------------------------------------------------------------
// gfx_cmd_fifo
// Synchronous command FIFO, DEPTH entries of WIDTH bits.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (empties FIFO)
//   push, push_data   write request and data (ignored when full)
//   pop               read request (ignored when empty)
//   head              current head entry, valid whenever !empty
//   full, empty       status flags
//   level             occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module gfx_cmd_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra MSB on each pointer: equal indices with differing MSBs
    // means the writer has lapped the reader (full).
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Head is read combinationally so the scheduler can capture it in the
    // same cycle it pops; a registered read would add a cycle of latency.
    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/graphics_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// graphics_cmd_scheduler
// Queues opcodes from a producer and dispatches them one at a time to three
// drawing engines (line, rect fill, rect move), waiting for each engine's
// done before issuing the next command.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   cmd_valid, cmd_op, cmd_ready  producer handshake (cmd_ready = !full)
//   *_start                       one-cycle start pulse per engine
//   *_done                        engine completion (pulse or level)
//   busy                          FSM not idle or FIFO not empty
//   level                         FIFO occupancy
//   bad_op                        pulse when an unknown opcode is dropped
//   timeout                       pulse when the watchdog aborts a WAIT
// Build option:
//   GFX_SCHED_TIMEOUT_EN  enables the WAIT watchdog (TIMEOUT_CYCLES); when
//                         undefined, timeout is tied low and WAIT never ends
//                         without the matching done.
// -----------------------------------------------------------------------------
module graphics_cmd_scheduler
    import gfx_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_op,
    output logic                      line_start,
    output logic                      rect_fill_start,
    output logic                      rect_move_start,
    input  logic                      line_done,
    input  logic                      rect_fill_done,
    input  logic                      rect_move_done,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      bad_op,
    output logic                      timeout
);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in 2..64");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..2^20-1");
    end

    sched_state_t state_reg;
    logic [31:0]  op_q_reg;
    logic         line_start_reg;
    logic         rect_fill_start_reg;
    logic         rect_move_start_reg;
    logic         bad_op_reg;

    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    logic [31:0]  fifo_head;
    logic         done_match;
    logic         wd_expire;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;

    gfx_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (cmd_op),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Only the engine that owns the in-flight command can end the WAIT.
    always_comb begin
        done_match = 1'b0;
        if (state_reg == WAIT) begin
            unique case (op_q_reg)
                LINE:      done_match = line_done;
                RECT_FILL: done_match = rect_fill_done;
                RECT_MOVE: done_match = rect_move_done;
                default:   done_match = 1'b0;
            endcase
        end
    end

`ifdef GFX_SCHED_TIMEOUT_EN
    logic [19:0] wd_cnt_reg;
    logic        timeout_reg;

    // A matching done in the expiry cycle takes priority over the abort.
    assign wd_expire = (state_reg == WAIT) && !done_match &&
                       (wd_cnt_reg == 20'(TIMEOUT_CYCLES - 1));

    // Cleared during ISSUE so the count is 0 on the first WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= wd_expire;
            if (state_reg == ISSUE) begin
                wd_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Start and bad_op pulses are decoded from the FIFO head at pop time so
    // that they appear, registered, exactly during the ISSUE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg           <= IDLE;
            op_q_reg            <= '0;
            line_start_reg      <= 1'b0;
            rect_fill_start_reg <= 1'b0;
            rect_move_start_reg <= 1'b0;
            bad_op_reg          <= 1'b0;
        end else begin
            line_start_reg      <= 1'b0;
            rect_fill_start_reg <= 1'b0;
            rect_move_start_reg <= 1'b0;
            bad_op_reg          <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_q_reg            <= fifo_head;
                        line_start_reg      <= (fifo_head == LINE);
                        rect_fill_start_reg <= (fifo_head == RECT_FILL);
                        rect_move_start_reg <= (fifo_head == RECT_MOVE);
                        bad_op_reg          <= !is_known_op(fifo_head);
                        state_reg           <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= is_known_op(op_q_reg) ? WAIT : IDLE;
                end
                WAIT: begin
                    if (done_match || wd_expire) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign line_start      = line_start_reg;
    assign rect_fill_start = rect_fill_start_reg;
    assign rect_move_start = rect_move_start_reg;
    assign bad_op          = bad_op_reg;
    assign busy            = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_graphics_cmd_scheduler.sv
module tb_graphics_cmd_scheduler;

    localparam int DEPTH = 8;
    localparam int TO    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef GFX_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // {starts[3], bad_op, timeout, busy, cmd_ready, level[4]} while in reset
    localparam logic [10:0] RESET_VEC = 11'b000_0_0_0_1_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [31:0]   cmd_op = '0;
    logic          line_done = 1'b0;
    logic          rect_fill_done = 1'b0;
    logic          rect_move_done = 1'b0;
    logic          cmd_ready;
    logic          line_start;
    logic          rect_fill_start;
    logic          rect_move_start;
    logic          busy;
    logic [LW-1:0] level;
    logic          bad_op;
    logic          timeout;

    graphics_cmd_scheduler #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .line_start      (line_start),
        .rect_fill_start (rect_fill_start),
        .rect_move_start (rect_move_start),
        .line_done       (line_done),
        .rect_fill_done  (rect_fill_done),
        .rect_move_done  (rect_move_done),
        .busy            (busy),
        .level           (level),
        .bad_op          (bad_op),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    wire [10:0] obs = {line_start, rect_fill_start, rect_move_start, bad_op,
                       timeout, busy, cmd_ready, level};

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a queue of pending opcodes plus the one in flight.
    // A dispatched command shows its start at m_acyc and waits from then on.
    int cyc = 0;
    int mq[$];
    bit m_act = 1'b0;
    int m_op  = 0;
    int m_acyc = 0;
    bit m_to  = 1'b0;

    function automatic bit known(input int op);
        return (op >= 1) && (op <= 3);
    endfunction

    function automatic bit done_for(input int op);
        if (op == 1) return line_done;
        if (op == 2) return rect_fill_done;
        if (op == 3) return rect_move_done;
        return 1'b0;
    endfunction

    function automatic logic [10:0] exp_vec();
        bit st;
        st = m_act && (m_acyc == cyc);
        return {st && (m_op == 1), st && (m_op == 2), st && (m_op == 3),
                st && !known(m_op), m_to, m_act || (mq.size() > 0),
                mq.size() < DEPTH, LW'(mq.size())};
    endfunction

    // Advance the model over the current cycle using the inputs now applied.
    task automatic model_step();
        bit rdy;
        rdy  = mq.size() < DEPTH;
        m_to = 1'b0;
        if (m_act) begin
            if (cyc == m_acyc) begin
                if (!known(m_op)) m_act = 1'b0;
            end else if (done_for(m_op)) begin
                m_act = 1'b0;
            end else if (TO_EN && (cyc - m_acyc - 1) == TO - 1) begin
                m_act = 1'b0;
                m_to  = 1'b1;
            end
        end else if (mq.size() > 0) begin
            m_op   = mq.pop_front();
            m_act  = 1'b1;
            m_acyc = cyc + 1;
        end
        if (cmd_valid && rdy) mq.push_back(int'(cmd_op));
        cyc++;
    endtask

    task automatic model_clear();
        mq.delete();
        m_act = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_op = '0;
        line_done = 1'b0;
        rect_fill_done = 1'b0;
        rect_move_done = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        line_done = 1'b1;
        rect_fill_done = 1'b1;
        rect_move_done = 1'b1;
        for (int i = 0; i < 200 && busy; i++) tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain busy=%b required=0", busy);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_state got=%b required=%b", obs, RESET_VEC);
        end
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release got=%b required=%b", obs, exp_vec());
        end
    endtask

    task automatic test_latency();
        int ls_n = 0;
        int ls_at = -1;
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            cmd_valid = (i == 0);
            cmd_op = 32'd1;
            line_done = (i == 10);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL latency cyc=%0d got=%b required=%b", i + 1, obs, exp_vec());
            end
            if (line_start) begin ls_n++; ls_at = i + 1; end
            if (i + 1 == 10 || i + 1 == 11) begin
                n_cmp++;
                if (busy !== (i + 1 == 10)) begin
                    n_fail++;
                    $display("FAIL latency_busy cyc=%0d busy=%b required=%b", i + 1, busy, i + 1 == 10);
                end
            end
        end
        n_cmp++;
        if (ls_n != 1 || ls_at != 2) begin
            n_fail++;
            $display("FAIL latency_start count=%0d at=%0d required=1 at 2", ls_n, ls_at);
        end
        $display("latency: line_start at cycle %0d", ls_at);
    endtask

    task automatic test_order();
        int order[$];
        int ops[3] = '{2, 3, 1};
        int pend = 0;
        int cd = 0;
        int peak = 0;
        for (int i = 0; i < 60; i++) begin
            idle_inputs();
            if (i < 3) begin
                cmd_valid = 1'b1;
                cmd_op = 32'(ops[i]);
            end
            if (pend != 0 && cd == 0) begin
                line_done = (pend == 1);
                rect_fill_done = (pend == 2);
                rect_move_done = (pend == 3);
                pend = 0;
            end
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL order cyc=%0d got=%b required=%b", i + 1, obs, exp_vec());
            end
            if (int'(level) > peak) peak = int'(level);
            if (line_start || rect_fill_start || rect_move_start) begin
                pend = line_start ? 1 : (rect_fill_start ? 2 : 3);
                order.push_back(pend);
                cd = $urandom_range(2, 5);
                $display("order: start op=%0d at cycle %0d", pend, i + 1);
            end else if (cd > 0) begin
                cd--;
            end
        end
        n_cmp++;
        if (order.size() != 3 || order[0] != 2 || order[1] != 3 || order[2] != 1) begin
            n_fail++;
            $display("FAIL order_seq count=%0d required=3 in order 2,3,1", order.size());
        end
        n_cmp++;
        if (peak < 2 || peak > 3) begin
            n_fail++;
            $display("FAIL order_peak level=%0d required=2..3", peak);
        end
        idle_inputs();
    endtask

    task automatic test_full();
        bit hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cmd_valid = 1'b1;
            cmd_op = 32'd2;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_fill cyc=%0d got=%b required=%b", i + 1, obs, exp_vec());
            end
            if (!cmd_ready) hit = 1'b1;
        end
        n_cmp++;
        if (!hit || level !== LW'(DEPTH) || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flag level=%0d ready=%b required level=%0d ready=0", level, cmd_ready, DEPTH);
        end
        cmd_op = 32'd3;
        tick();
        n_cmp++;
        if (level !== LW'(DEPTH) || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_ninth level=%0d got=%b required=%b", level, obs, exp_vec());
        end
        cmd_valid = 1'b0;
        rect_fill_done = 1'b1;
        tick();
        rect_fill_done = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b0 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL full_pop_cycle got=%b required=%b", obs, exp_vec());
        end
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || level !== LW'(DEPTH - 1)) begin
            n_fail++;
            $display("FAIL full_ready_after_pop ready=%b level=%0d required ready=1 level=%0d", cmd_ready, level, DEPTH - 1);
        end
        drain();
    endtask

    task automatic test_bad_op();
        int bad_n = 0, bad_at = -1, st_n = 0, rf_at = -1;
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            cmd_valid = (i < 2);
            cmd_op = (i == 0) ? 32'd7 : 32'd2;
            line_done = (i == 6);
            rect_move_done = (i == 7);
            rect_fill_done = (i == 10);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL bad_op cyc=%0d got=%b required=%b", i + 1, obs, exp_vec());
            end
            if (bad_op) begin bad_n++; bad_at = i + 1; end
            if (line_start || rect_fill_start || rect_move_start) st_n++;
            if (rect_fill_start) rf_at = i + 1;
            if (i + 1 == 9) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bad_op_stray_done busy=%b required=1", busy);
                end
            end
        end
        n_cmp++;
        if (bad_n != 1 || bad_at != 2 || st_n != 1 || rf_at != 4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_op_seq bad=%0d@%0d starts=%0d rf@%0d busy=%b required 1@2 1 rf@4 busy=0", bad_n, bad_at, st_n, rf_at, busy);
        end
        $display("bad_op: pulse at cycle %0d, rect_fill start at cycle %0d", bad_at, rf_at);
    endtask

`ifdef GFX_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            int to_n = 0, to_at = -1;
            for (int i = 0; i < 25; i++) begin
                idle_inputs();
                cmd_valid = (i == 0);
                cmd_op = 32'd3;
                rect_move_done = (pass == 1) && (i == 18);
                tick();
                n_cmp++;
                if (obs !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL timeout pass=%0d cyc=%0d got=%b required=%b", pass, i + 1, obs, exp_vec());
                end
                if (timeout) begin to_n++; to_at = i + 1; end
            end
            n_cmp++;
            if ((pass == 0 && (to_n != 1 || to_at != 19)) || (pass == 1 && to_n != 0) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_pulse pass=%0d count=%0d at=%0d busy=%b", pass, to_n, to_at, busy);
            end
            $display("timeout: pass %0d pulses=%0d at cycle %0d", pass, to_n, to_at);
        end
    endtask
`else
    task automatic test_timeout();
        int to_n = 0;
        for (int i = 0; i < 40; i++) begin
            idle_inputs();
            cmd_valid = (i == 0);
            cmd_op = 32'd3;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL no_timeout cyc=%0d got=%b required=%b", i + 1, obs, exp_vec());
            end
            if (timeout) to_n++;
        end
        n_cmp++;
        if (to_n != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout_wait pulses=%0d busy=%b required 0 and busy=1", to_n, busy);
        end
        drain();
    endtask
`endif

    task automatic test_reset_mid_wait();
        int st_n = 0;
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            cmd_valid = (i < 5);
            cmd_op = 32'((i % 3) + 1);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL rst_wait_fill cyc=%0d got=%b required=%b", i + 1, obs, exp_vec());
            end
        end
        n_cmp++;
        if (level !== LW'(4) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_level level=%0d busy=%b required 4 and 1", level, busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL rst_wait_async got=%b required=%b", obs, RESET_VEC);
        end
        model_clear();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            line_done = (i < 2);
            rect_fill_done = (i == 1);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL rst_wait_late cyc=%0d got=%b required=%b", i + 1, obs, exp_vec());
            end
            if (line_start || rect_fill_start || rect_move_start) st_n++;
        end
        n_cmp++;
        if (st_n != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_no_start starts=%0d busy=%b required 0 and 0", st_n, busy);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            int pick;
            pick = $urandom_range(0, 7);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = (pick < 6) ? 32'((pick % 3) + 1) : ((pick == 6) ? 32'd0 : 32'd9);
            line_done = ($urandom_range(0, 3) == 0);
            rect_fill_done = ($urandom_range(0, 3) == 0);
            rect_move_done = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                errs++;
                if (errs < 10) $display("FAIL random cyc=%0d got=%b required=%b", i + 1, obs, exp_vec());
            end
        end
        $display("random: 600 cycles, %0d deviations", errs);
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_order();
        test_full();
        test_bad_op();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
